// File: rtl/ov7670_camera_model.sv
// ov7670_camera_model: OV7670-style DVP source (pclk/vsync/href/RGB565 bytes) with test patterns.
// Frame state, byte slot and line counters only move on pclk fall events, so outputs are stable at each pclk rise.
module ov7670_camera_model #(
    parameter int H_ACTIVE    = 320,
    parameter int V_ACTIVE    = 240,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10,
    parameter int CLK_DIV     = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] patternSel,
    output logic       pclk,
    output logic       vsync,
    output logic       href,
    output logic [7:0] data,
    output logic       frameDone,
    output logic [7:0] frameCount
);
    typedef enum logic [2:0] {IDLE, VSYNC, BACK, ACTIVE, FRONT} state_t;

    localparam int LINE  = 2 * H_ACTIVE + H_BLANK;
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int DW    = CLK_DIV > 0 ? $clog2(CLK_DIV + 1) : 1;
    localparam int IW    = BAR_W > 1 ? $clog2(BAR_W) : 1;
    localparam logic [DW-1:0] DIV_MAX   = DW'(CLK_DIV);
    localparam logic [IW-1:0] INBAR_MAX = IW'(BAR_W - 1);
    localparam logic [15:0]   SLOT_MAX  = 16'(LINE - 1);
    localparam logic [15:0]   HREF_END  = 16'(2 * H_ACTIVE);
    localparam logic [15:0]   BARS [8]  = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    state_t         state_q, state_d, state_nxt;
    logic [DW-1:0]  div_q;
    logic           pclk_q;
    logic [15:0]    slot_q, slot_d, line_q, line_d, line_lim;
    logic [1:0]     pat_q, pat_d;
    logic [2:0]     bar_q, bar_d;
    logic [IW-1:0]  inbar_q, inbar_d;
    logic           done_q, done_d;
    logic [7:0]     count_q, count_d;
    logic           div_hit, fall, slot_end, last_line, frame_end, href_w;
    logic [7:0]     col8, row8;
    logic [15:0]    pixel;

    assign div_hit   = div_q == DIV_MAX;
    assign fall      = div_hit && pclk_q;
    assign slot_end  = slot_q == SLOT_MAX;
    assign line_lim  = state_q == VSYNC  ? 16'(VSYNC_LINES - 1) :
                       state_q == BACK   ? 16'(V_BACK - 1) :
                       state_q == ACTIVE ? 16'(V_ACTIVE - 1) : 16'(V_FRONT - 1);
    assign last_line = line_q == line_lim;
    assign frame_end = fall && state_q == FRONT && slot_end && last_line;
    assign state_nxt = state_q == VSYNC  ? BACK :
                       state_q == BACK   ? ACTIVE :
                       state_q == ACTIVE ? FRONT :
                       enable            ? VSYNC : IDLE;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        line_d  = line_q;
        pat_d   = pat_q;
        bar_d   = bar_q;
        inbar_d = inbar_q;
        done_d  = frame_end;
        count_d = count_q + 8'(frame_end);
        if (fall && state_q == IDLE) begin
            state_d = enable ? VSYNC : IDLE;
            pat_d   = enable ? patternSel : pat_q;
        end else if (fall) begin
            slot_d = slot_end ? 16'd0 : slot_q + 16'd1;
            line_d = !slot_end ? line_q : last_line ? 16'd0 : line_q + 16'd1;
            if (slot_end && last_line) begin
                state_d = state_nxt;
                pat_d   = state_q == FRONT && enable ? patternSel : pat_q;
            end
            // Bar index advances after the second byte of the last pixel in each bar.
            if (slot_end) begin
                bar_d   = 3'd0;
                inbar_d = '0;
            end else if (slot_q[0]) begin
                inbar_d = inbar_q == INBAR_MAX ? '0 : inbar_q + 1'b1;
                bar_d   = bar_q + 3'(inbar_q == INBAR_MAX);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= '0;
            pclk_q  <= 1'b0;
            state_q <= IDLE;
            slot_q  <= '0;
            line_q  <= '0;
            pat_q   <= '0;
            bar_q   <= '0;
            inbar_q <= '0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            div_q   <= div_hit ? '0 : div_q + 1'b1;
            pclk_q  <= pclk_q ^ div_hit;
            state_q <= state_d;
            slot_q  <= slot_d;
            line_q  <= line_d;
            pat_q   <= pat_d;
            bar_q   <= bar_d;
            inbar_q <= inbar_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign col8   = slot_q[8:1];
    assign row8   = line_q[7:0];
    assign pixel  = pat_q == 2'd0 ? BARS[bar_q] :
                    pat_q == 2'd1 ? {row8, col8} :
                    pat_q == 2'd2 ? 16'hF800 : {16{col8[3] ^ row8[3]}};
    assign href_w = state_q == ACTIVE && slot_q < HREF_END;

    assign pclk       = pclk_q;
    assign vsync      = state_q == VSYNC;
    assign href       = href_w;
    assign data       = !href_w ? 8'd0 : slot_q[0] ? pixel[7:0] : pixel[15:8];
    assign frameDone  = done_q;
    assign frameCount = count_q;
endmodule

// File: tb/tb_ov7670_camera_model.sv
// tb_ov7670_camera_model: directed checks of frame timing, patterns, enable/pattern latching and counter wrap.
// dut_a runs the pattern/timing frames with a divided pclk; dut_b is a tiny frame used for the 256-frame wrap.
module tb_ov7670_camera_model;
    logic clk = 1'b0, reset = 1'b1;
    logic en_a = 1'b0, en_b = 1'b0;
    logic [1:0] sel_a = 2'd0, sel_b = 2'd0;
    logic pclk_a, vsync_a, href_a, done_a, pclk_b, vsync_b, href_b, done_b;
    logic [7:0] data_a, count_a, data_b, count_b;
    always #5 clk = ~clk;

    ov7670_camera_model #(.H_ACTIVE(16), .V_ACTIVE(4), .H_BLANK(4), .VSYNC_LINES(1),
                          .V_BACK(1), .V_FRONT(1), .CLK_DIV(1)) dut_a (
        .clk(clk), .reset(reset), .enable(en_a), .patternSel(sel_a), .pclk(pclk_a),
        .vsync(vsync_a), .href(href_a), .data(data_a), .frameDone(done_a), .frameCount(count_a));

    ov7670_camera_model #(.H_ACTIVE(8), .V_ACTIVE(1), .H_BLANK(1), .VSYNC_LINES(1),
                          .V_BACK(1), .V_FRONT(1), .CLK_DIV(0)) dut_b (
        .clk(clk), .reset(reset), .enable(en_b), .patternSel(sel_b), .pclk(pclk_b),
        .vsync(vsync_b), .href(href_b), .data(data_b), .frameDone(done_b), .frameCount(count_b));

    int total = 0, bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Captures dut_a frames at pclk rise: bytes per frame/row, plus per-frame timing stats.
    logic [7:0] mem [5][4][32];
    int len_a [5][4];
    int fidx = 0, fcnt = 0, vs_cnt = 0, first_href = 0, row = -1, bi = 0, blank_nz = 0;
    initial begin
        logic pv, ph;
        pv = 1'b0;
        ph = 1'b0;
        forever begin
            @(posedge pclk_a);
            if (vsync_a && !pv) begin
                fidx++; fcnt = 0; vs_cnt = 0; first_href = 0; row = -1;
            end
            fcnt++;
            if (vsync_a) vs_cnt++;
            if (href_a) begin
                if (!ph) begin
                    row++; bi = 0;
                    if (first_href == 0) first_href = fcnt;
                end
                if (fidx < 5 && row >= 0 && row < 4 && bi < 32) mem[fidx][row][bi] = data_a;
                bi++;
                if (fidx < 5 && row >= 0 && row < 4) len_a[fidx][row] = bi;
            end else if (data_a != 8'd0) blank_nz++;
            pv = vsync_a;
            ph = href_a;
        end
    end

    // Any change of vsync/href/data must coincide with pclk going 1->0.
    initial begin
        logic [9:0] pout, cur;
        logic pp, prst;
        pout = '0; pp = 1'b0; prst = 1'b1;
        forever begin
            @(negedge clk);
            cur = {vsync_a, href_a, data_a};
            if (!reset && !prst && cur != pout) chk("a_change_on_fall", int'(pp && !pclk_a), 1);
            pout = cur; pp = pclk_a; prst = reset;
        end
    end

    task automatic wait_done_a();
        bit ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            ok = done_a;
        end
        chk("a_done_seen", int'(ok), 1);
    endtask

    task automatic check_frame_a(input int f);
        chk("a_frame_idx", fidx, f);
        chk("a_frame_pclks", fcnt, 252);
        chk("a_vsync_pclks", vs_cnt, 36);
        chk("a_first_href_pclk", first_href, 73);
        chk("a_href_lines", row + 1, 4);
        for (int r = 0; r < 4; r++) chk("a_line_bytes", len_a[f][r], 32);
        chk("a_frame_count", int'(count_a), f);
        @(negedge clk);
        chk("a_done_one_clk", int'(done_a), 0);
    endtask

    typedef struct {int f; int r; int c; logic [15:0] px;} vec_t;
    vec_t tbl [19] = '{
        '{1, 2, 0, 16'h0200}, '{1, 2, 15, 16'h020F}, '{1, 0, 5, 16'h0005}, '{1, 3, 9, 16'h0309},
        '{2, 0, 0, 16'hFFFF}, '{2, 0, 1, 16'hFFFF}, '{2, 0, 2, 16'hFFE0}, '{2, 0, 4, 16'h07FF},
        '{2, 0, 6, 16'h07E0}, '{2, 1, 8, 16'hF81F}, '{2, 2, 10, 16'hF800}, '{2, 3, 12, 16'h001F},
        '{2, 0, 15, 16'h0000}, '{3, 1, 7, 16'hF800}, '{3, 3, 15, 16'hF800},
        '{4, 0, 0, 16'h0000}, '{4, 2, 8, 16'hFFFF}, '{4, 3, 15, 16'hFFFF}, '{4, 1, 7, 16'h0000}};

    initial begin
        int n, chg, gap;
        logic pa, pb, seen;
        repeat (5) @(negedge clk);
        chk("a_reset_outputs", int'({pclk_a, vsync_a, href_a, data_a, done_a, count_a}), 0);
        chk("b_reset_outputs", int'({pclk_b, vsync_b, href_b, data_b, done_b, count_b}), 0);
        reset = 1'b0;
        pa = pclk_a; pb = pclk_b; chg = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("b_pclk_toggle", int'(pclk_b), int'(!pb));
            chk("b_idle_outputs", int'({vsync_b, href_b, data_b, count_b}), 0);
            chg += int'(pclk_a != pa);
            pa = pclk_b == pclk_b ? pclk_a : pa;
            pb = pclk_b;
        end
        chk("a_pclk_toggles_20clk", chg, 10);
        chk("a_idle_outputs", int'({vsync_a, href_a, data_a, count_a}), 0);

        en_a = 1'b1; sel_a = 2'd1; n = 0;
        while (!vsync_a && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("a_vsync_latency", int'(vsync_a && n >= 1 && n <= 4), 1);
        sel_a = 2'd0;
        wait_done_a(); check_frame_a(1);
        repeat (100) @(negedge clk);
        sel_a = 2'd2;
        wait_done_a(); check_frame_a(2);
        repeat (100) @(negedge clk);
        sel_a = 2'd3;
        wait_done_a(); check_frame_a(3);
        repeat (100) @(negedge clk);
        en_a = 1'b0;
        wait_done_a(); check_frame_a(4);
        seen = 1'b0;
        repeat (300) begin
            @(negedge clk);
            seen |= vsync_a | href_a;
        end
        chk("a_idle_after_disable", int'(seen), 0);
        chk("a_count_held", int'(count_a), 4);
        chk("a_blank_data_zero", blank_nz, 0);

        for (int i = 0; i < 19; i++) begin
            chk($sformatf("px_f%0d_r%0d_c%0d_hi", tbl[i].f, tbl[i].r, tbl[i].c),
                int'(mem[tbl[i].f][tbl[i].r][2 * tbl[i].c]), int'(tbl[i].px[15:8]));
            chk($sformatf("px_f%0d_r%0d_c%0d_lo", tbl[i].f, tbl[i].r, tbl[i].c),
                int'(mem[tbl[i].f][tbl[i].r][2 * tbl[i].c + 1]), int'(tbl[i].px[7:0]));
        end

        en_b = 1'b1;
        for (int k = 0; k < 256; k++) begin
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (!done_b && gap < 400);
            chk("b_done_seen", int'(done_b), 1);
            if (k > 0) chk("b_frame_period", gap, 136);
            chk("b_no_gap_vsync", int'(vsync_b), 1);
            chk("b_frame_count", int'(count_b), (k + 1) % 256);
        end
        en_b = 1'b0;

        en_a = 1'b1; n = 0;
        while (!href_a && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("a_reached_active", int'(href_a), 1);
        chk("a_count_before_reset", int'(count_a), 4);
        #2 reset = 1'b1;
        #1 chk("a_async_reset_outputs", int'({pclk_a, vsync_a, href_a, data_a, done_a, count_a}), 0);
        en_a = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("a_count_after_reset", int'(count_a), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ov7670_camera_model.md
Name: ov7670_camera_model

Overview:
- Synthesizable OV7670 sensor-side DVP source: generates pclk, vsync, href and an 8-bit RGB565 byte stream with OV7670 frame timing.
- Drives the camera-input pins of the capture path (frame grabber, pixel sink) in simulation and in on-board loopback.
- Frees capture-path bring-up from real-sensor dependency.
- Produces deterministic test patterns with a frame counter for checking.

Parameters:
- H_ACTIVE, 320, active pixels per line (2 byte slots each); multiple of 8
- V_ACTIVE, 240, active lines per frame
- H_BLANK, 144, blank byte slots per line after active bytes, ≥1
- VSYNC_LINES, 3, lines with vsync high
- V_BACK, 17, blank lines after vsync, before active
- V_FRONT, 10, blank lines after active region
- CLK_DIV, 0, pclk half-period = CLK_DIV+1 clk cycles

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- enable  in  1  request frames; sampled at frame boundaries only
- patternSel  in  2  test pattern; latched at frame start
- pclk  out  1  pixel clock; data valid at rising edge
- vsync  out  1  frame sync, active high
- href  out  1  high while active bytes are presented
- data  out  8  RGB565 byte; high byte first
- frameDone  out  1  one-clk pulse at end of each frame
- frameCount  out  8  completed frames, wraps 255->0

Behaviour:
- Reset values: pclk=0, vsync=0, href=0, data=0, frameDone=0, frameCount=0, state=IDLE, all counters 0.
- pclk: divider counts 0..CLK_DIV. pclk toggles and the divider clears on match. Runs continuously after reset, including IDLE.
- Fall event: the clk edge where pclk goes 1->0. All of vsync/href/data/state/slot counters update only on fall events, so they are stable across each rising edge.
- Line = 2*H_ACTIVE + H_BLANK byte slots. Slot counter wraps to 0 at line end; line counter advances on wrap.
- States and transitions, all on fall events:
  - IDLE: outputs low. If enable=1: latch patternSel, go to VSYNC, vsync=1 on this same fall event.
  - VSYNC: vsync=1, href=0 for VSYNC_LINES lines, then go to BACK.
  - BACK: vsync=0, href=0 for V_BACK lines, then go to ACTIVE.
  - ACTIVE: V_ACTIVE lines. Slots 0..2*H_ACTIVE-1: href=1, data = pixel[15:8] on even slot, pixel[7:0] on odd slot. Blank slots: href=0, data=0. Then go to FRONT.
  - FRONT: V_FRONT lines of blanking. At end of last line:
    - frameDone pulses high for exactly one clk.
    - frameCount increments in that same cycle.
    - If enable=1: relatch patternSel and go directly to VSYNC with no gap slot.
    - Else go to IDLE.
- Pixel (col 0..H_ACTIVE-1, row 0..V_ACTIVE-1):
  - 0, colour bars: bar = col/(H_ACTIVE/8), via in-bar counter, no divider. Values per bar: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 1, ramp: {row[7:0], col[7:0]}.
  - 2, solid: F800.
  - 3, checker: col[3]^row[3] ? FFFF : 0000.
- enable deassert mid-frame: the current frame completes normally, then IDLE.
- patternSel change mid-frame: ignored until next frame start.
- Reset mid-frame: all outputs return to reset values asynchronously. The partial frame is not counted.
- Timing latency: enable rise -> vsync high at the next fall event (≤ 2*(CLK_DIV+1) clk).

Test Plan:
Common setup: H_ACTIVE=8, V_ACTIVE=4, H_BLANK=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1.
- Reset, CLK_DIV=0, enable=0, hold 20 clk -> pclk toggles every clk; vsync/href/data/frameCount stay 0.
- Reset release, CLK_DIV=1 -> pclk period 4 clk; outputs change only on falling pclk edges.
- enable=1, patternSel=1, CLK_DIV=0, one frame ->
  - vsync high for 20 pclk.
  - 20 pclk blank, then 4 lines each of 16 href-high bytes and 4 blank.
  - Row 2 bytes: 02,00,02,01,...,02,07.
  - frameDone single pulse after 140 pclk; frameCount=1.
- patternSel=0, H_ACTIVE=16 -> row 0 bytes are FF,FF,FF,FF,FF,E0,FF,E0,07,FF,07,FF, ..., final pixel bytes 00,00.
- patternSel changed 0->2 mid-frame -> current frame stays bars; next frame all pixels F8,00.
- Cases at frame boundaries and reset:
  - enable dropped mid-frame 2 -> frame completes, frameCount=2, then IDLE with vsync=0.
  - Enable continuously held -> 256 frames; frameCount wraps to 0; no gap slot between frames.
  - Reset pulsed mid-ACTIVE -> all outputs 0 immediately; frameCount=0.
